// File: rtl/creditor_if.sv
// rtl/creditor_if.sv - credit grant channel between creditor and the upstream debtor
interface creditor_if #(
    parameter int TRANCHE_WIDTH = 3
);
    logic                     grant;
    logic [TRANCHE_WIDTH-1:0] grant_tranche;
    logic                     grant_ready;

    modport master (
        output grant,
        output grant_tranche,
        input  grant_ready
    );

    modport slave (
        input  grant,
        input  grant_tranche,
        output grant_ready
    );
endinterface

// File: rtl/creditor.sv
// rtl/creditor.sv - receiver-side credit issuer; optional partial-tranche flush timer under CREDITOR_TIMEOUT_EN
module creditor #(
    parameter int WIDTH         = 4,
    parameter int TRANCHE_WIDTH = 3,
    parameter int CAPACITY      = 8,
    parameter int THRESHOLD     = 2,
    parameter int TIMEOUT       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recv,
    input  logic             consume,
    creditor_if.master       g,
    output logic [WIDTH-1:0] outstanding,
    output logic             error
);
    localparam logic [31:0] TMAX  = 32'((1 << TRANCHE_WIDTH) - 1);
    localparam logic [31:0] THR   = 32'(THRESHOLD);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                   state, state_nxt;
    logic [WIDTH-1:0]         pending, pending_nxt, outstanding_nxt;
    logic [TRANCHE_WIDTH-1:0] tranche, tranche_nxt;
    logic                     error_nxt;
    logic                     hs, buf_empty, recv_ok, consume_ok;
    logic [WIDTH-1:0]         hs_amt;
    logic [WIDTH:0]           held;
    logic                     timeout_hit;

    assign hs         = g.grant & g.grant_ready;
    assign hs_amt     = hs ? WIDTH'(tranche) : '0;
    assign held       = {1'b0, pending} + {1'b0, outstanding};
    // Every credit is either pending, outstanding, or a word sitting in the buffer.
    assign buf_empty  = (held == (WIDTH+1)'(CAPACITY));
    assign recv_ok    = recv & (outstanding != '0);
    assign consume_ok = consume & ~buf_empty;

`ifdef CREDITOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer, timer_nxt;

    always_comb begin
        timer_nxt   = '0;
        timeout_hit = 1'b0;
        if (state == IDLE && pending != '0 && 32'(pending) < THR) begin
            if (timer == TW'(TIMEOUT - 1))
                timeout_hit = 1'b1;
            else
                timer_nxt = timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            timer <= '0;
        else
            timer <= timer_nxt;
    end
`else
    // Without the timer, partial credits simply wait; the expression is constant 0.
    assign timeout_hit = (TIMEOUT < 0);
`endif

    always_comb begin
        state_nxt   = state;
        tranche_nxt = tranche;
        case (state)
            IDLE: begin
                if (32'(pending) >= THR) begin
                    state_nxt   = OFFER;
                    tranche_nxt = (32'(pending) > TMAX) ? TRANCHE_WIDTH'(TMAX)
                                                         : TRANCHE_WIDTH'(pending);
                end else if (timeout_hit) begin
                    state_nxt   = OFFER;
                    tranche_nxt = TRANCHE_WIDTH'(pending);
                end
            end
            OFFER: begin
                if (hs)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pending_nxt     = pending + WIDTH'(consume_ok) - hs_amt;
        outstanding_nxt = outstanding - WIDTH'(recv_ok) + hs_amt;
        error_nxt       = error | (recv & (outstanding == '0)) | (consume & buf_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pending     <= WIDTH'(CAPACITY);
            outstanding <= '0;
            tranche     <= '0;
            error       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            outstanding <= outstanding_nxt;
            tranche     <= tranche_nxt;
            error       <= error_nxt;
        end
    end

    assign g.grant         = (state == OFFER);
    assign g.grant_tranche = tranche;
endmodule
